// File: rtl/dii_package.sv
// ============================================================================
// Module      : dii_package
// Description : DII flit type and debug-ring arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dii_package;

    localparam int DII_DATA_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } dii_arb_state_t;

endpackage : dii_package

`default_nettype wire

// File: rtl/debug_rr_select.sv
// ============================================================================
// Module      : debug_rr_select
// Description : Combinational rotate-priority one-hot picker starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_rr_select #(
    parameter int PORTS = 2,
    parameter int PTR_W = 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    always_comb begin : p_pick
        int               w_sum;
        logic [PTR_W-1:0] w_idx;
        logic             w_found;
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= PORTS) begin
                w_sum = w_sum - PORTS;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

endmodule : debug_rr_select

`default_nettype wire

// File: rtl/debug_ring_arbiter.sv
// ============================================================================
// Module      : debug_ring_arbiter
// Description : Packet-level round-robin arbiter sharing one DII flit output.
//               DEBUG_RING_ARBITER_OUTREG_EN adds a 2-entry output skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_ring_arbiter
    import dii_package::*;
#(
    parameter int PORTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  dii_flit          arb_in [PORTS],
    output logic [PORTS-1:0] arb_in_ready,
    output dii_flit          arb_out,
    input  logic             arb_out_ready,
    output logic [PORTS-1:0] grant,
    output logic             busy
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    dii_arb_state_t   r_state;
    logic [PORTS-1:0] r_owner;
    logic [PTR_W-1:0] r_owner_idx;
    logic [PTR_W-1:0] r_ptr;

    logic [PORTS-1:0] w_req;
    logic [PORTS-1:0] w_pick;
    logic [PTR_W-1:0] w_pick_idx;
    logic [PORTS-1:0] w_grant;
    logic [PTR_W-1:0] w_sel_idx;
    dii_flit          w_sel_flit;
    logic             w_accept;
    logic             w_xfer;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        if (int'(idx) >= PORTS - 1) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

    for (genvar g = 0; g < PORTS; g++) begin : g_req
        assign w_req[g] = arb_in[g].valid;
    end

    debug_rr_select #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_select (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_pick),
        .gnt_idx (w_pick_idx)
    );

    // Reset gates the grant so outputs go quiet in the same cycle rst rises.
    always_comb begin
        w_grant   = '0;
        w_sel_idx = '0;
        if (!rst) begin
            if (r_state == ARB_LOCKED) begin
                w_grant   = r_owner;
                w_sel_idx = r_owner_idx;
            end else begin
                w_grant   = w_pick;
                w_sel_idx = w_pick_idx;
            end
        end
        w_sel_flit = '0;
        if ((|w_grant) && arb_in[w_sel_idx].valid) begin
            w_sel_flit = arb_in[w_sel_idx];
        end
    end

    assign grant  = w_grant;
    assign busy   = (r_state == ARB_LOCKED);
    assign w_xfer = w_sel_flit.valid && w_accept;

`ifdef DEBUG_RING_ARBITER_OUTREG_EN
    dii_flit    r_head;
    dii_flit    r_tail;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign w_accept     = (r_cnt != 2'd2);
    assign w_push       = w_xfer;
    assign w_pop        = (r_cnt != 2'd0) && arb_out_ready;
    assign arb_in_ready = w_grant & {PORTS{w_accept}};
    assign arb_out      = (r_cnt != 2'd0) ? r_head : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= w_sel_flit;
                    end else begin
                        r_tail <= w_sel_flit;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                // Push and pop together only happen with exactly one entry held.
                2'b11: begin
                    r_head <= w_sel_flit;
                end
                default: begin
                end
            endcase
        end
    end
`else
    assign w_accept     = arb_out_ready;
    assign arb_in_ready = w_grant & {PORTS{arb_out_ready}};
    assign arb_out      = w_sel_flit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_owner     <= '0;
            r_owner_idx <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_sel_flit.valid) begin
                        if (w_xfer && w_sel_flit.last) begin
                            r_ptr <= next_idx(w_pick_idx);
                        end else begin
                            // Also lock on an unaccepted offer so the flit stays stable.
                            r_owner     <= w_pick;
                            r_owner_idx <= w_pick_idx;
                            r_state     <= ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (w_xfer && w_sel_flit.last) begin
                        r_state <= ARB_IDLE;
                        r_owner <= '0;
                        r_ptr   <= next_idx(r_owner_idx);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : debug_ring_arbiter

`default_nettype wire
